// File: rtl/jesd_mon_pkg.sv
// rtl/jesd_mon_pkg.sv - shared types and helpers for the JESD refclk monitor
package jesd_mon_pkg;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} sel_state_t;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Inclusive unsigned range test applied to each closed window count.
  function automatic logic in_range(input logic [31:0] count,
                                    input logic [31:0] min_cnt,
                                    input logic [31:0] max_cnt);
    return (count >= min_cnt) && (count <= max_cnt);
  endfunction

endpackage

// File: rtl/jesd_refclk_chan.sv
// rtl/jesd_refclk_chan.sv - one refclk channel: synchroniser, edge counter, lock FSM
module jesd_refclk_chan
  import jesd_mon_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 120,
  parameter int EXP_MAX      = 136,
  parameter int LOCK_WINDOWS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clk_div,
  input  logic             win_close,
  output logic [CNT_W-1:0] win_count,
  output logic             locked,
  output logic             locked_next,
  output logic             lost_evt
);

  localparam int STREAK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [STREAK_W-1:0] LOCK_TGT = STREAK_W'(LOCK_WINDOWS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q;
  logic [STREAK_W-1:0]    streak_q;
  logic [STREAK_W-1:0]    streak_d;
  lock_state_t            state_q;
  lock_state_t            state_d;
  logic                   win_in_range;

  // Bring the divided refclk into the clk domain and keep one delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Window value includes an edge seen on the closing cycle; counter sticks at all-ones.
  assign win_count    = (rise && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  assign win_in_range = in_range(32'(win_count), 32'(EXP_MIN), 32'(EXP_MAX));

  // Edge counter restarts on every window close so the next cycle's edge lands in the new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (!enable || win_close)  cnt_q <= '0;
    else                            cnt_q <= win_count;
  end

  // Lock state and good-window streak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UNLOCKED;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Lock qualification, evaluated only when a window closes.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    lost_evt = 1'b0;
    if (!enable) begin
      state_d  = UNLOCKED;
      streak_d = '0;
    end else if (win_close) begin
      case (state_q)
        UNLOCKED: begin
          if (win_in_range) begin
            streak_d = streak_q + 1'b1;
            if (streak_d == LOCK_TGT) state_d = LOCKED;
          end else begin
            streak_d = '0;
          end
        end
        LOCKED: begin
          if (!win_in_range) begin
            state_d  = UNLOCKED;
            streak_d = '0;
            lost_evt = 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  assign locked      = (state_q == LOCKED);
  assign locked_next = (state_d == LOCKED);

endmodule

// File: rtl/jesd_refclk_monitor.sv
// rtl/jesd_refclk_monitor.sv - multi-channel refclk frequency monitor with failover select
module jesd_refclk_monitor
  import jesd_mon_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int GATE_CYCLES  = 1024,
  parameter int EXP_MIN      = 120,
  parameter int EXP_MAX      = 136,
  parameter int LOCK_WINDOWS = 4,
  parameter int SYNC_STAGES  = 2,
  localparam int CH_IDX_W    = ch_idx_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       clk_div_i,
  input  logic                    clr_lost,
  output logic [NUM_CH*CNT_W-1:0] freq_count_o,
  output logic                    freq_valid_o,
  output logic [NUM_CH-1:0]       ch_locked_o,
  output logic [NUM_CH-1:0]       ch_lost_o,
  output logic [CH_IDX_W-1:0]     active_ch_o,
  output logic                    sel_valid_o,
  output logic                    switch_o
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0]       gate_q;
  logic                    win_close;
  logic [NUM_CH*CNT_W-1:0] win_count;
  logic [NUM_CH-1:0]       locked_nx;
  logic [NUM_CH-1:0]       lost_evt;
  sel_state_t              sel_q;
  sel_state_t              sel_d;
  logic [CH_IDX_W-1:0]     act_d;
  logic [CH_IDX_W-1:0]     low_idx;
  logic                    sw_d;

  assign win_close = enable && (gate_q == GATE_LAST);

  // Gate counter: free-runs over the window while enabled, restarts at 0 on re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     gate_q <= '0;
    else if (!enable || win_close)  gate_q <= '0;
    else                            gate_q <= gate_q + 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    jesd_refclk_chan #(
      .CNT_W        (CNT_W),
      .EXP_MIN      (EXP_MIN),
      .EXP_MAX      (EXP_MAX),
      .LOCK_WINDOWS (LOCK_WINDOWS),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .clk_div     (clk_div_i[k]),
      .win_close   (win_close),
      .win_count   (win_count[k*CNT_W +: CNT_W]),
      .locked      (ch_locked_o[k]),
      .locked_next (locked_nx[k]),
      .lost_evt    (lost_evt[k])
    );
  end

  // Latch closed-window counts with a one-cycle valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_count_o <= '0;
      freq_valid_o <= 1'b0;
    end else begin
      freq_valid_o <= win_close;
      if (win_close) freq_count_o <= win_count;
    end
  end

  // Sticky loss flags; a new loss beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_lost_o <= '0;
    else        ch_lost_o <= (clr_lost ? '0 : ch_lost_o) | lost_evt;
  end

  // Lowest-index channel that will be locked after this edge.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (locked_nx[k]) low_idx = CH_IDX_W'(k);
    end
  end

  // Non-revertive selection: only leave the active channel when it drops lock.
  always_comb begin
    sel_d = sel_q;
    act_d = active_ch_o;
    sw_d  = 1'b0;
    if (!enable) begin
      sel_d = IDLE;
    end else begin
      case (sel_q)
        IDLE: begin
          if (|locked_nx) begin
            sel_d = ACTIVE;
            act_d = low_idx;
          end
        end
        ACTIVE: begin
          if (!locked_nx[active_ch_o]) begin
            if (|locked_nx) begin
              act_d = low_idx;
              sw_d  = 1'b1;
            end else begin
              sel_d = IDLE;
            end
          end
        end
        default: sel_d = IDLE;
      endcase
    end
  end

  // Selection state, active index and switch pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= IDLE;
      active_ch_o <= '0;
      switch_o    <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      active_ch_o <= act_d;
      switch_o    <= sw_d;
    end
  end

  assign sel_valid_o = (sel_q == ACTIVE);

endmodule
